mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single-ported unified memory of the memory-to-memory vector processor. It sits between the memory and two masters: port 0, the multicycle control/datapath (instruction fetch, operand read, result write-back), and port 1, the vector element streaming engine. It grants one single-word transaction per cycle using round-robin arbitration. A requester can lock the port for back-to-back transactions, and a lock-hold limit bounds the wait of the other master.

## Interface
- ADDR_W, 16, memory word address width
- DATA_W, 16, memory data width
- MAX_LOCK, 8, max consecutive locked grants while the other port waits (≥1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  transaction request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  keep ownership after this granted transaction
- gnt0 / gnt1  out  1  combinational; transaction accepted this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle
- rdata0 / rdata1  out  DATA_W  direct fan-out of mem_rdata
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid one cycle after a read command

## Operation
- State register st has three states: IDLE, LOCK0 and LOCK1. Supporting registers:
  - last: index of the last served port; reset value 1, so port 0 wins first.
  - lcnt: lock counter, $clog2(MAX_LOCK+1) bits.
  - rtag: 2 bits, {port1 read, port0 read} issued last cycle.
- IDLE arbitration:
  - Only one req active: grant that port.
  - Both active: grant port !last.
  - Neither active: mem_en=0.
- LOCKn arbitration:
  - If reqn=1, grant port n regardless of the other port.
  - If reqn=0, the lock is released this cycle, the other port is arbitrated as in IDLE, and the next state follows the new grant's lock bit.
- On a grant to port n:
  - mem_en=1; mem_we, mem_addr and mem_wdata are muxed from port n.
  - last←n at the clock edge.
  - If wen=0, set rtag[n].
- Next state after a grant to port n:
  - lockn=1 → LOCKn.
  - Otherwise → IDLE, with lcnt←0.
- Lock limit:
  - In LOCKn, each grant to n while the other port's req=1 increments lcnt.
  - When that grant makes lcnt reach MAX_LOCK, lockn is ignored: state→IDLE, lcnt←0, last=n, so the other port wins the next cycle.
  - Grants made while the other port is idle do not increment lcnt.
- Outputs with no grant: mem_we=0; mem_addr and mem_wdata=0.
- Reset values: st=IDLE, last=1, lcnt=0, rtag=0, gnt*=0, rvalid*=0, mem_en=0, mem_we=0.
- Reset mid-transaction: an in-flight read is dropped (rvalid stays 0) and no write is issued after reset asserts.

## Timing
- Grant: same cycle as req, combinational; zero added latency. The requester may change its request fields on the edge after gnt.
- Write: committed at the edge ending the grant cycle.
- Read: rvalidn=1 and rdatan=mem_rdata in the cycle after the grant; exactly one cycle wide.
- Throughput: one transaction per cycle. Alternating round-robin under continuous contention.
- A requester holding req without a grant keeps its fields stable; the arbiter never drops a request.
- Worst-case wait for an unlocked contender is MAX_LOCK+1 cycles.
- Simultaneous release and request: when port n releases (reqn=0) in LOCKn while the other port requests, the other port is granted that same cycle.
- Reset is asynchronous; outputs take their reset values immediately. The first grant is possible in the first cycle after reset deasserts.

## Test plan
- Single reads: req0 read addr 0x0010 (mem=0x1234), then req1 read 0x0020 (0x5678).
  - Required: gnt same cycle; rvalid0 with 0x1234 one cycle later, then rvalid1 with 0x5678; no cross-valid.
- Contention: req0 and req1 held for 6 cycles after reset with lock=0.
  - Required: grant order 0,1,0,1,0,1; mem_addr alternates accordingly.
- Lock then release: port 0 writes 0xAAAA to 0x0100 and 0xBBBB to 0x0101 with lock0=1 on the first beat, lock0=0 on the second; req1 pending throughout.
  - Required: port 0 granted both consecutive cycles; port 1 granted in the third cycle.
- Lock limit: MAX_LOCK=8, port 1 holds lock1=1 with req1 continuous, port 0 requests continuously.
  - Required: exactly 8 consecutive gnt1, then gnt0; lcnt returns to 0.
- Lock release by req drop: LOCK0 with req0 dropped while req1=1.
  - Required: gnt1 in that same cycle; state IDLE (or LOCK1 if lock1=1).
- Reset mid-read: assert reset in the cycle after a port 0 read grant.
  - Required: rvalid0 stays 0, mem_en=0; after reset deasserts, contention grants port 0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the unified single-ported memory shared by the
// control/datapath (port 0) and the vector streaming engine (port 1).
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LCNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t            st, stNext;
  logic              last, lastNext;
  logic [LCNT_W-1:0] lcnt, lcntNext;
  logic [1:0]        rtag, rtagNext;

  // State and bookkeeping registers; async reset drops any in-flight read tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= IDLE;
      last <= 1'b1;
      lcnt <= '0;
      rtag <= '0;
    end else begin
      st   <= stNext;
      last <= lastNext;
      lcnt <= lcntNext;
      rtag <= rtagNext;
    end
  end

  // Next state: lock entry/exit, hold-limit counting and round-robin history.
  always_comb begin
    stNext   = st;
    lastNext = last;
    lcntNext = lcnt;
    rtagNext = '0;
    if (gnt0) begin
      lastNext    = 1'b0;
      rtagNext[0] = ~we0;
      if (st == LOCK0) begin
        if (req1 && (lcnt == LCNT_W'(MAX_LOCK - 1))) begin
          stNext   = IDLE;
          lcntNext = '0;
        end else if (!lock0) begin
          stNext   = IDLE;
          lcntNext = '0;
        end else if (req1) begin
          lcntNext = lcnt + LCNT_W'(1);
        end
      end else begin
        stNext   = lock0 ? LOCK0 : IDLE;
        lcntNext = '0;
      end
    end else if (gnt1) begin
      lastNext    = 1'b1;
      rtagNext[1] = ~we1;
      if (st == LOCK1) begin
        if (req0 && (lcnt == LCNT_W'(MAX_LOCK - 1))) begin
          stNext   = IDLE;
          lcntNext = '0;
        end else if (!lock1) begin
          stNext   = IDLE;
          lcntNext = '0;
        end else if (req0) begin
          lcntNext = lcnt + LCNT_W'(1);
        end
      end else begin
        stNext   = lock1 ? LOCK1 : IDLE;
        lcntNext = '0;
      end
    end else if (st != IDLE) begin
      stNext   = IDLE;
      lcntNext = '0;
    end
  end

  // Grant selection and memory command mux; held quiet while reset is high.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (st)
        LOCK0: begin
          if (req0) gnt0 = 1'b1;
          else      gnt1 = req1;
        end
        LOCK1: begin
          if (req1) gnt1 = 1'b1;
          else      gnt0 = req0;
        end
        default: begin
          if (req0 && req1) begin
            gnt0 = last;
            gnt1 = ~last;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
    mem_en = gnt0 | gnt1;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rvalid0 = rtag[0];
  assign rvalid1 = rtag[1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for lock limit, lock release and reset.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, write on the grant edge.
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      mem[12'h010] <= 16'h1234;
      mem[12'h020] <= 16'h5678;
      mem[12'h030] <= 16'h3030;
      mem[12'h040] <= 16'h4040;
      mem[12'h200] <= 16'h2222;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[11:0]];
    end
  end

  typedef struct {
    int unsigned r0, r1, w0, w1, l0, l1, a0, a1, d0, d1;
    int unsigned g0, g1, we, addr, wd, v0, v1, rd;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  int  lockCnt;
  bit  seen;

  initial begin
    //            r0 r1 w0 w1 l0 l1 a0     a1     d0      d1  g0 g1 we addr   wd      v0 v1 rd
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,     0,     0,      0,  0, 0, 0, 0,     0,      0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 'h10,  0,     0,      0,  1, 0, 0, 'h10,  0,      0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 0,     'h20,  0,      0,  0, 1, 0, 'h20,  0,      1, 0, 'h1234};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,     0,     0,      0,  0, 0, 0, 0,     0,      0, 1, 'h5678};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 'h30,  'h40,  0,      0,  1, 0, 0, 'h30,  0,      0, 0, 0};
    vecs[5]  = '{1, 1, 0, 0, 0, 0, 'h30,  'h40,  0,      0,  0, 1, 0, 'h40,  0,      1, 0, 'h3030};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, 'h30,  'h40,  0,      0,  1, 0, 0, 'h30,  0,      0, 1, 'h4040};
    vecs[7]  = '{1, 1, 0, 0, 0, 0, 'h30,  'h40,  0,      0,  0, 1, 0, 'h40,  0,      1, 0, 'h3030};
    vecs[8]  = '{1, 1, 0, 0, 0, 0, 'h30,  'h40,  0,      0,  1, 0, 0, 'h30,  0,      0, 1, 'h4040};
    vecs[9]  = '{1, 1, 0, 0, 0, 0, 'h30,  'h40,  0,      0,  0, 1, 0, 'h40,  0,      1, 0, 'h3030};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0,     0,     0,      0,  0, 0, 0, 0,     0,      0, 1, 'h4040};
    vecs[11] = '{1, 1, 1, 0, 1, 0, 'h100, 'h200, 'hAAAA, 0,  1, 0, 1, 'h100, 'hAAAA, 0, 0, 0};
    vecs[12] = '{1, 1, 1, 0, 0, 0, 'h101, 'h200, 'hBBBB, 0,  1, 0, 1, 'h101, 'hBBBB, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 0, 0, 0,     'h200, 0,      0,  0, 1, 0, 'h200, 0,      0, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 0, 'h100, 0,     0,      0,  1, 0, 0, 'h100, 0,      0, 1, 'h2222};
    vecs[15] = '{1, 0, 0, 0, 0, 0, 'h101, 0,     0,      0,  1, 0, 0, 'h101, 0,      1, 0, 'hAAAA};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0,     0,     0,      0,  0, 0, 0, 0,     0,      1, 0, 'hBBBB};

    // Reset state with both requests asserted: nothing may be granted.
    reset = 1'b1;
    drive(1, 1, 1, 1, 0, 0, 16'h10, 16'h20, 16'h1, 16'h2);
    #2;
    chk("reset gnt0", 32'(gnt0), 0);
    chk("reset gnt1", 32'(gnt1), 0);
    chk("reset mem_en", 32'(mem_en), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset rvalid0", 32'(rvalid0), 0);
    chk("reset rvalid1", 32'(rvalid1), 0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Table: single reads, round-robin contention, lock then release.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].r0[0], vecs[i].r1[0], vecs[i].w0[0], vecs[i].w1[0], vecs[i].l0[0],
            vecs[i].l1[0], vecs[i].a0[15:0], vecs[i].a1[15:0], vecs[i].d0[15:0], vecs[i].d1[15:0]);
      @(negedge clk);
      chk($sformatf("v%0d gnt0", i), 32'(gnt0), vecs[i].g0);
      chk($sformatf("v%0d gnt1", i), 32'(gnt1), vecs[i].g1);
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), vecs[i].g0 | vecs[i].g1);
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), vecs[i].we);
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), vecs[i].addr);
      chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), vecs[i].wd);
      chk($sformatf("v%0d rvalid0", i), 32'(rvalid0), vecs[i].v0);
      chk($sformatf("v%0d rvalid1", i), 32'(rvalid1), vecs[i].v1);
      if (vecs[i].v0 != 0) chk($sformatf("v%0d rdata0", i), 32'(rdata0), vecs[i].rd);
      if (vecs[i].v1 != 0) chk($sformatf("v%0d rdata1", i), 32'(rdata1), vecs[i].rd);
      nextCycle();
    end

    // Lock limit: port 1 enters LOCK1 alone, then port 0 waits for 8 grants.
    drive(0, 1, 0, 0, 0, 1, 16'h10, 16'h20, 16'h0, 16'h0);
    @(negedge clk);
    chk("limit entry gnt1", 32'(gnt1), 1);
    nextCycle();
    drive(1, 1, 0, 0, 0, 1, 16'h10, 16'h20, 16'h0, 16'h0);
    lockCnt = 0;
    seen    = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt0) begin
        seen = 1'b1;
        chk("limit lcnt cleared", 32'(dut.lcnt), 0);
        chk("limit gnt1 low at gnt0", 32'(gnt1), 0);
      end else if (gnt1) begin
        lockCnt++;
      end
      nextCycle();
    end
    chk("limit gnt0 reached", 32'(seen), 1);
    chk("limit locked grants", 32'(lockCnt), 8);
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    nextCycle();

    // Release by req drop into IDLE: port 1 granted in the release cycle.
    drive(1, 0, 0, 0, 1, 0, 16'h30, 16'h40, 16'h0, 16'h0);
    @(negedge clk);
    chk("relA lock gnt0", 32'(gnt0), 1);
    nextCycle();
    drive(0, 1, 0, 0, 0, 0, 16'h30, 16'h40, 16'h0, 16'h0);
    @(negedge clk);
    chk("relA gnt1", 32'(gnt1), 1);
    chk("relA gnt0", 32'(gnt0), 0);
    chk("relA addr", 32'(mem_addr), 32'h40);
    nextCycle();
    drive(1, 1, 0, 0, 0, 0, 16'h30, 16'h40, 16'h0, 16'h0);
    @(negedge clk);
    chk("relA idle rr gnt0", 32'(gnt0), 1);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    nextCycle();

    // Release by req drop with lock1 set: port 1 keeps the port afterwards.
    drive(1, 0, 0, 0, 1, 0, 16'h30, 16'h40, 16'h0, 16'h0);
    @(negedge clk);
    chk("relB lock gnt0", 32'(gnt0), 1);
    nextCycle();
    drive(0, 1, 0, 0, 0, 1, 16'h30, 16'h40, 16'h0, 16'h0);
    @(negedge clk);
    chk("relB gnt1", 32'(gnt1), 1);
    nextCycle();
    drive(1, 1, 0, 0, 0, 0, 16'h30, 16'h40, 16'h0, 16'h0);
    @(negedge clk);
    chk("relB locked gnt1", 32'(gnt1), 1);
    chk("relB locked gnt0", 32'(gnt0), 0);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    nextCycle();

    // Reset in the cycle after a port 0 read grant.
    drive(1, 0, 0, 0, 0, 0, 16'h10, 16'h20, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst read gnt0", 32'(gnt0), 1);
    nextCycle();
    reset = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 16'h30, 16'h40, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst rvalid0", 32'(rvalid0), 0);
    chk("rst mem_en", 32'(mem_en), 0);
    chk("rst gnt0", 32'(gnt0), 0);
    chk("rst gnt1", 32'(gnt1), 0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post rst gnt0", 32'(gnt0), 1);
    chk("post rst gnt1", 32'(gnt1), 0);
    chk("post rst addr", 32'(mem_addr), 32'h30);
    chk("post rst rvalid0", 32'(rvalid0), 0);
    nextCycle();
    @(negedge clk);
    chk("post rst rr gnt1", 32'(gnt1), 1);
    chk("post rst rvalid0 read", 32'(rvalid0), 1);
    chk("post rst rdata0", 32'(rdata0), 32'h3030);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
